// File: rtl/nic_defs.sv
// Shared NIC definitions: RPC header/packet types and the connection-steering
// table entry format used by the TX flow steering front end.
package nic_defs;

    // Number of CCI-P lines per batch (log2).
    localparam int LMAX_CCIP_BATCH = 2;

    // Default widths of the connection id and the NIC flow id.
    localparam int CONN_ID_WIDTH = 4;
    localparam int FLOW_ID_WIDTH = 1;

    // RPC header as exchanged between the RPC side and the transmitter.
    typedef struct packed {
        logic [15:0] rpc_id;
        logic [7:0]  n_of_frames;
        logic [7:0]  fn_id;
        logic [31:0] argl;
        logic [31:0] argr;
    } RpcIf;

    // RPC together with its position inside a CCI-P batch.
    typedef struct packed {
        RpcIf                       rpc;
        logic [LMAX_CCIP_BATCH-1:0] batch_idx;
    } RpcPckt;

    // Connection id and the connection table entry it selects.
    typedef logic [CONN_ID_WIDTH-1:0] ConnId;

    typedef struct packed {
        logic                     valid;
        logic [FLOW_ID_WIDTH-1:0] flow;
    } FlowSteerEntry;

endpackage

// File: rtl/rpc_steer_fifo.sv
// Synchronous single-clock FIFO with occupancy counter, full/empty flags and
// simultaneous push/pop. A push into a full FIFO is accepted only when a pop
// happens in the same cycle; otherwise it is discarded.
module rpc_steer_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int LDEPTH     = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  full,
    output logic                  empty
);

    localparam int DEPTH = 1 << LDEPTH;
    localparam logic [LDEPTH:0] DEPTH_CNT = (LDEPTH + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [LDEPTH-1:0]     wr_ptr;
    logic [LDEPTH-1:0]     rd_ptr;
    logic [LDEPTH:0]       count;
    logic [LDEPTH:0]       count_next;
    logic                  do_push;
    logic                  do_pop;

    assign full    = (count == DEPTH_CNT);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rd_data = mem[rd_ptr];

    // Next occupancy from the accepted push/pop pair.
    // NOTE: always_comb assigns a default first so no path leaves count_next unassigned (no latch).
    always_comb begin
        count_next = count;
        case ({do_push, do_pop})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    // Pointer, counter and registered empty flag update.
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            empty  <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count_next;
            empty <= (count_next == '0);
        end
    end

    // Storage write port.
    // NOTE: the data array is not reset; the pointers and counter define which words are valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/rpc_tx_flow_steering.sv
// RPC TX flow steering: resolves each outgoing RPC's connection id to a NIC TX
// flow id via a CSR-programmed connection table, buffers {RPC, flow} in an
// ingress FIFO and feeds the CCI-P transmitter while it reports ready.
// Optional statistics counters are enabled with `define RPC_TX_STEER_STATS_EN.
module rpc_tx_flow_steering
    import nic_defs::*;
#(
    parameter int LMAX_NUM_OF_FLOWS = FLOW_ID_WIDTH,
    parameter int LCONN_TABLE_SIZE  = CONN_ID_WIDTH,
    parameter int LFIFO_DEPTH       = 3,
    parameter int NIC_ID            = 0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [LMAX_NUM_OF_FLOWS-1:0] number_of_flows,
    input  logic [$bits(RpcIf)-1:0]      rpc_in,
    input  logic                         rpc_in_valid,
    input  logic [LCONN_TABLE_SIZE-1:0]  conn_id_in,
    input  logic                         tbl_wr_en,
    input  logic [LCONN_TABLE_SIZE-1:0]  tbl_wr_addr,
    input  logic [LMAX_NUM_OF_FLOWS-1:0] tbl_wr_flow,
    input  logic                         ccip_tx_ready,
    output logic [$bits(RpcIf)-1:0]      rpc_out,
    output logic                         rpc_out_valid,
    output logic [LMAX_NUM_OF_FLOWS-1:0] rpc_flow_id_out,
    output logic                         fifo_empty,
    output logic                         pdrop_out
`ifdef RPC_TX_STEER_STATS_EN
    ,
    output logic [31:0]                  drop_cnt_out,
    output logic [31:0]                  fwd_cnt_out
`endif
);

    localparam int TBL_SIZE = 1 << LCONN_TABLE_SIZE;
    localparam int RPC_W    = $bits(RpcIf);
    localparam int FIFO_W   = RPC_W + LMAX_NUM_OF_FLOWS;

    // Table entry sized by this instance's parameters (same layout as FlowSteerEntry).
    typedef struct packed {
        logic                         valid;
        logic [LMAX_NUM_OF_FLOWS-1:0] flow;
    } steer_entry_t;

    steer_entry_t                 conn_table [TBL_SIZE];

    logic                         s1_valid;
    logic [RPC_W-1:0]             s1_rpc;
    logic [LMAX_NUM_OF_FLOWS-1:0] s1_conn_lsb;
    steer_entry_t                 s1_entry;

    logic [LMAX_NUM_OF_FLOWS-1:0] s2_cand;
    logic [LMAX_NUM_OF_FLOWS-1:0] s2_flow;

    logic                         fifo_push;
    logic                         fifo_pop;
    logic                         fifo_full;
    logic [FIFO_W-1:0]            fifo_rd_data;

    // Connection table: CSR writes set the entry and its valid bit. The table
    // is cleared on reset so unprogrammed connections fall back to conn-id routing.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < TBL_SIZE; i++) conn_table[i] <= '0;
        end else if (tbl_wr_en) begin
            conn_table[tbl_wr_addr] <= '{valid: 1'b1, flow: tbl_wr_flow};
        end
    end

    // Stage 1: capture the RPC and the table entry; a same-cycle write returns the old entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid    <= 1'b0;
            s1_rpc      <= '0;
            s1_conn_lsb <= '0;
            s1_entry    <= '0;
        end else begin
            s1_valid    <= rpc_in_valid && start;
            s1_rpc      <= rpc_in;
            s1_conn_lsb <= conn_id_in[LMAX_NUM_OF_FLOWS-1:0];
            s1_entry    <= conn_table[conn_id_in];
        end
    end

    // Stage 2: pick stored flow or conn-id fallback, then clamp to the active flow range.
    always_comb begin
        s2_cand = s1_entry.valid ? s1_entry.flow : s1_conn_lsb;
        s2_flow = (s2_cand > number_of_flows) ? '0 : s2_cand;
    end

    assign fifo_push = s1_valid && start;
    assign fifo_pop  = !fifo_empty && ccip_tx_ready && start;

    rpc_steer_fifo #(
        .DATA_WIDTH (FIFO_W),
        .LDEPTH     (LFIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .wr_data ({s1_rpc, s2_flow}),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Registered transmitter interface and drop pulse; a same-cycle pop makes room for the push.
    always_ff @(posedge clk) begin
        if (reset) begin
            rpc_out         <= '0;
            rpc_flow_id_out <= '0;
            rpc_out_valid   <= 1'b0;
            pdrop_out       <= 1'b0;
        end else begin
            rpc_out_valid <= fifo_pop;
            pdrop_out     <= fifo_push && fifo_full && !fifo_pop;
            if (fifo_pop) begin
                rpc_out         <= fifo_rd_data[FIFO_W-1 -: RPC_W];
                rpc_flow_id_out <= fifo_rd_data[LMAX_NUM_OF_FLOWS-1:0];
            end
        end
    end

`ifdef RPC_TX_STEER_STATS_EN
    // Statistics: saturating drop counter and wrapping forward counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            drop_cnt_out <= '0;
            fwd_cnt_out  <= '0;
        end else begin
            if (pdrop_out && (drop_cnt_out != '1)) drop_cnt_out <= drop_cnt_out + 1'b1;
            if (rpc_out_valid)                     fwd_cnt_out  <= fwd_cnt_out + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_rpc_tx_flow_steering.sv
// Testbench for rpc_tx_flow_steering: directed stimulus, a queue-based
// reference model compared every cycle, plus hand-computed literal checks.
module tb_rpc_tx_flow_steering;
    import nic_defs::*;

    localparam int LMF   = 1;
    localparam int LCT   = 4;
    localparam int LFD   = 3;
    localparam int DEPTH = 1 << LFD;
    localparam int RW    = $bits(RpcIf);

    logic           clk;
    logic           reset;
    logic           start;
    logic [LMF-1:0] number_of_flows;
    logic [RW-1:0]  rpc_in;
    logic           rpc_in_valid;
    logic [LCT-1:0] conn_id_in;
    logic           tbl_wr_en;
    logic [LCT-1:0] tbl_wr_addr;
    logic [LMF-1:0] tbl_wr_flow;
    logic           ccip_tx_ready;
    logic [RW-1:0]  rpc_out;
    logic           rpc_out_valid;
    logic [LMF-1:0] rpc_flow_id_out;
    logic           fifo_empty;
    logic           pdrop_out;
`ifdef RPC_TX_STEER_STATS_EN
    logic [31:0]    drop_cnt_out;
    logic [31:0]    fwd_cnt_out;
`endif

    rpc_tx_flow_steering #(
        .LMAX_NUM_OF_FLOWS (LMF),
        .LCONN_TABLE_SIZE  (LCT),
        .LFIFO_DEPTH       (LFD),
        .NIC_ID            (0)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .number_of_flows (number_of_flows),
        .rpc_in          (rpc_in),
        .rpc_in_valid    (rpc_in_valid),
        .conn_id_in      (conn_id_in),
        .tbl_wr_en       (tbl_wr_en),
        .tbl_wr_addr     (tbl_wr_addr),
        .tbl_wr_flow     (tbl_wr_flow),
        .ccip_tx_ready   (ccip_tx_ready),
        .rpc_out         (rpc_out),
        .rpc_out_valid   (rpc_out_valid),
        .rpc_flow_id_out (rpc_flow_id_out),
        .fifo_empty      (fifo_empty),
        .pdrop_out       (pdrop_out)
`ifdef RPC_TX_STEER_STATS_EN
        ,
        .drop_cnt_out    (drop_cnt_out),
        .fwd_cnt_out     (fwd_cnt_out)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic check(input string name, input logic [127:0] actual, input logic [127:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    function automatic RpcIf make_rpc(input int id);
        RpcIf r;
        r.rpc_id      = 16'h0100 + id[15:0];
        r.n_of_frames = 8'd1;
        r.fn_id       = id[7:0];
        r.argl        = 32'hA000_0000 | id;
        r.argr        = ~r.argl;
        return r;
    endfunction

    // Flow selection rule: programmed flow, else low conn-id bits; out-of-range -> 0.
    function automatic logic [LMF-1:0] resolve(input logic tv, input logic [LMF-1:0] tf,
                                               input logic [LCT-1:0] conn, input logic [LMF-1:0] nof);
        int f;
        f = tv ? int'(tf) : (int'(conn) % (1 << LMF));
        return (f > int'(nof)) ? '0 : f[LMF-1:0];
    endfunction

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [RW-1:0]  rpc;
        logic [LMF-1:0] flow;
    } exp_t;

    exp_t           mq[$];
    logic           m_tv [1 << LCT];
    logic [LMF-1:0] m_tf [1 << LCT];
    logic           m_s1_valid;
    logic [RW-1:0]  m_s1_rpc;
    logic [LCT-1:0] m_s1_conn;
    logic           m_s1_tv;
    logic [LMF-1:0] m_s1_tf;
    logic           exp_valid, exp_drop, exp_empty;
    logic [RW-1:0]  exp_rpc;
    logic [LMF-1:0] exp_flow;
    int             m_fwd, m_drop;
    logic           cmp_en = 1'b0;

    always @(posedge clk) begin
        bit   pop, push;
        exp_t e;
        if (reset) begin
            mq.delete();
            for (int i = 0; i < (1 << LCT); i++) begin
                m_tv[i] = 1'b0;
                m_tf[i] = '0;
            end
            m_s1_valid = 1'b0;
            exp_valid  = 1'b0;
            exp_drop   = 1'b0;
            exp_rpc    = '0;
            exp_flow   = '0;
            m_fwd      = 0;
            m_drop     = 0;
        end else begin
            pop       = (mq.size() != 0) && ccip_tx_ready && start;
            push      = m_s1_valid && start;
            exp_valid = pop;
            exp_drop  = 1'b0;
            if (pop) begin
                e        = mq.pop_front();
                exp_rpc  = e.rpc;
                exp_flow = e.flow;
                m_fwd++;
            end
            if (push) begin
                if (mq.size() < DEPTH) begin
                    e.rpc  = m_s1_rpc;
                    e.flow = resolve(m_s1_tv, m_s1_tf, m_s1_conn, number_of_flows);
                    mq.push_back(e);
                end else begin
                    exp_drop = 1'b1;
                    m_drop++;
                end
            end
            m_s1_valid = rpc_in_valid && start;
            m_s1_rpc   = rpc_in;
            m_s1_conn  = conn_id_in;
            m_s1_tv    = m_tv[conn_id_in];
            m_s1_tf    = m_tf[conn_id_in];
            if (tbl_wr_en) begin
                m_tv[tbl_wr_addr] = 1'b1;
                m_tf[tbl_wr_addr] = tbl_wr_flow;
            end
        end
        exp_empty = (mq.size() == 0);
    end

    // Per-cycle compare against the model, away from the active edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("rpc_out_valid", rpc_out_valid, exp_valid);
            check("pdrop_out", pdrop_out, exp_drop);
            check("fifo_empty", fifo_empty, exp_empty);
            check("rpc_out", rpc_out, exp_rpc);
            check("rpc_flow_id_out", rpc_flow_id_out, exp_flow);
        end
    end

    int outs_seen  = 0;
    int drops_seen = 0;
    always @(negedge clk) begin
        if (rpc_out_valid === 1'b1) outs_seen++;
        if (pdrop_out === 1'b1)     drops_seen++;
    end

    // ---------------- stimulus helpers (entered just after a negedge) ----------------
    task automatic drive_rpc(input int conn, input int id);
        rpc_in_valid = 1'b1;
        conn_id_in   = conn[LCT-1:0];
        rpc_in       = make_rpc(id);
    endtask

    task automatic idle(input int n);
        rpc_in_valid = 1'b0;
        tbl_wr_en    = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic tbl_write(input int conn, input int flow);
        tbl_wr_en   = 1'b1;
        tbl_wr_addr = conn[LCT-1:0];
        tbl_wr_flow = flow[LMF-1:0];
        @(negedge clk);
        tbl_wr_en   = 1'b0;
    endtask

    // Single RPC on an idle pipe: valid must appear exactly 3 cycles later.
    task automatic send_and_expect(input string name, input int conn, input int id, input int flow);
        RpcIf r;
        r = make_rpc(id);
        drive_rpc(conn, id);
        @(negedge clk);
        rpc_in_valid = 1'b0;
        check({name, " N+1 valid"}, rpc_out_valid, 0);
        @(negedge clk);
        check({name, " N+2 valid"}, rpc_out_valid, 0);
        @(negedge clk);
        check({name, " N+3 valid"}, rpc_out_valid, 1);
        check({name, " flow"}, rpc_flow_id_out, flow);
        check({name, " payload"}, rpc_out, r);
        @(negedge clk);
    endtask

    int o0, d0;

    initial begin
        reset           = 1'b1;
        start           = 1'b0;
        number_of_flows = '0;
        rpc_in          = '0;
        rpc_in_valid    = 1'b0;
        conn_id_in      = '0;
        tbl_wr_en       = 1'b0;
        tbl_wr_addr     = '0;
        tbl_wr_flow     = '0;
        ccip_tx_ready   = 1'b0;

        @(negedge clk);
        cmp_en = 1'b1;
        check("reset rpc_out_valid", rpc_out_valid, 0);
        check("reset pdrop_out", pdrop_out, 0);
        check("reset fifo_empty", fifo_empty, 1);
        check("reset rpc_out", rpc_out, 0);
        check("reset flow", rpc_flow_id_out, 0);
        repeat (2) @(negedge clk);
        reset           = 1'b0;
        start           = 1'b1;
        number_of_flows = 1'b1;
        ccip_tx_ready   = 1'b1;
        idle(1);

        // Programmed connection, unprogrammed fallback and range clamping.
        tbl_write(5, 1);
        send_and_expect("conn5 hit", 5, 1, 1);
        send_and_expect("conn3 fallback", 3, 2, 1);
        number_of_flows = 1'b0;
        send_and_expect("conn2 nof0", 2, 3, 0);
        send_and_expect("conn5 clamp", 5, 4, 0);
        number_of_flows = 1'b1;

        // start low: inputs ignored, nothing forwarded or dropped.
        start = 1'b0;
        o0 = outs_seen;
        d0 = drops_seen;
        drive_rpc(3, 5);
        @(negedge clk);
        idle(5);
        start = 1'b1;
        idle(4);
        check("start low outs", outs_seen - o0, 0);
        check("start low drops", drops_seen - d0, 0);

        // Overflow: ready low, 10 back-to-back RPCs into depth 8.
        ccip_tx_ready = 1'b0;
        o0 = outs_seen;
        d0 = drops_seen;
        for (int i = 0; i < 10; i++) begin
            drive_rpc(i, 10 + i);
            @(negedge clk);
        end
        idle(3);
        check("overflow drops", drops_seen - d0, 2);
        check("overflow fifo_empty", fifo_empty, 0);
`ifdef RPC_TX_STEER_STATS_EN
        check("stats drop_cnt", drop_cnt_out, 2);
`endif

        // Full FIFO: push lands on the same edge as the first pop -> no drop.
        drive_rpc(1, 30);
        @(negedge clk);
        rpc_in_valid  = 1'b0;
        ccip_tx_ready = 1'b1;
        idle(12);
        check("drain outs", outs_seen - o0, 9);
        check("push+pop full drops", drops_seen - d0, 2);
        check("drain fifo_empty", fifo_empty, 1);

        // Table write colliding with a lookup of the same connection.
        tbl_wr_en   = 1'b1;
        tbl_wr_addr = 4'd7;
        tbl_wr_flow = 1'b0;
        drive_rpc(7, 40);
        @(negedge clk);
        tbl_wr_en = 1'b0;
        drive_rpc(7, 41);
        check("collide N+1 valid", rpc_out_valid, 0);
        @(negedge clk);
        rpc_in_valid = 1'b0;
        check("collide N+2 valid", rpc_out_valid, 0);
        @(negedge clk);
        check("collide old valid", rpc_out_valid, 1);
        check("collide old flow", rpc_flow_id_out, 1);
        check("collide old payload", rpc_out, make_rpc(40));
        @(negedge clk);
        check("collide new valid", rpc_out_valid, 1);
        check("collide new flow", rpc_flow_id_out, 0);
        check("collide new payload", rpc_out, make_rpc(41));
        idle(3);

        // Reset with 4 entries queued: everything discarded, no drop pulse.
        ccip_tx_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive_rpc(i, 50 + i);
            @(negedge clk);
        end
        idle(3);
        check("queued fifo_empty", fifo_empty, 0);
        d0 = drops_seen;
        reset = 1'b1;
        idle(2);
        reset         = 1'b0;
        ccip_tx_ready = 1'b1;
        o0 = outs_seen;
        idle(10);
        check("post reset outs", outs_seen - o0, 0);
        check("post reset drops", drops_seen - d0, 0);
        check("post reset fifo_empty", fifo_empty, 1);

        // Traffic after reset uses the cleared table (conn 7 falls back to flow 1).
        send_and_expect("post reset conn7", 7, 60, 1);
        idle(2);
`ifdef RPC_TX_STEER_STATS_EN
        check("stats fwd_cnt", fwd_cnt_out, m_fwd);
        check("stats drop_cnt end", drop_cnt_out, m_drop);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/rpc_tx_flow_steering.md
Name: rpc_tx_flow_steering

Overview:
- Upstream feeder of the CCI-P transmitter.
- Accepts outgoing RPCs from the RPC/network side, each tagged with a connection id.
- Resolves the connection id to a NIC TX flow id through a CSR-programmable connection table, buffers the result in an ingress FIFO, and drives the transmitter interface (RpcIf, valid, flow id) only while the transmitter reports ccip_tx_ready.
- Drops and flags RPCs on FIFO overflow.

Parameters:
- LMAX_NUM_OF_FLOWS, 1, log2 of max NIC flows; matches the transmitter.
- LCONN_TABLE_SIZE, 4, log2 of connection table entries.
- LFIFO_DEPTH, 3, log2 of ingress FIFO depth.
- NIC_ID, 0, NIC instance id, used for display messages only.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  enable forwarding; inputs while low are ignored, not dropped
- number_of_flows  in  LMAX_NUM_OF_FLOWS  highest active flow index
- rpc_in  in  $bits(RpcIf)  RPC from the RPC side
- rpc_in_valid  in  1  rpc_in qualifier
- conn_id_in  in  LCONN_TABLE_SIZE  connection id of rpc_in
- tbl_wr_en  in  1  connection table write strobe (CSR)
- tbl_wr_addr  in  LCONN_TABLE_SIZE  table entry written
- tbl_wr_flow  in  LMAX_NUM_OF_FLOWS  flow id stored; write also sets the entry's valid bit
- ccip_tx_ready  in  1  transmitter ready (not almost-full)
- rpc_out  out  $bits(RpcIf)  RPC to transmitter
- rpc_out_valid  out  1  rpc_out qualifier
- rpc_flow_id_out  out  LMAX_NUM_OF_FLOWS  resolved flow id
- fifo_empty  out  1  ingress FIFO empty
- pdrop_out  out  1  one-cycle pulse per dropped RPC

Behaviour:
- Reset:
  - All table valid bits, the FIFO and pipeline registers are cleared.
  - rpc_out_valid=0, pdrop_out=0, fifo_empty=1, rpc_out=0, rpc_flow_id_out=0.
  - Reset mid-operation discards FIFO contents and in-flight stage registers without asserting pdrop_out.
- Stage 1 (lookup), on cycle N:
  - Registers rpc_in, conn_id_in and the table entry at conn_id_in.
  - The stage valid bit = rpc_in_valid && start.
- Table write/read collision: a write in cycle N to the address being looked up returns the old entry; the new entry is visible from N+1.
- Stage 2 (resolve), cycle N+1:
  - Entry valid: flow = stored flow.
  - Entry invalid: flow = conn_id[LMAX_NUM_OF_FLOWS-1:0] if that value is <= number_of_flows, else 0.
  - A hit whose stored flow is > number_of_flows is also forced to 0.
  - The resolved {RpcIf, flow} is pushed into the FIFO.
- Push into a full FIFO:
  - The entry is dropped and pdrop_out pulses at N+2.
  - If a pop occurs in the same cycle, the FIFO counts as not full: push and pop both proceed, no drop.
- Pop condition: !empty && ccip_tx_ready && start. Outputs are registered, so rpc_out_valid asserts on the cycle after the pop, for one cycle per RPC.
- Latency: minimum input-to-rpc_out_valid is 3 cycles (N+3) with the FIFO empty and ready high. Sustained throughput is 1 RPC/cycle.
- ccip_tx_ready low: pops stop immediately. At most 0 further rpc_out_valid after the cycle following deassertion; the transmitter's almost-full slack covers this.
- start low: no pushes, no pops. FIFO contents are retained.
- FIFO structure: occupancy counter LFIFO_DEPTH+1 bits; read and write pointers wrap modulo depth. fifo_empty is registered from the counter.
- Ordering: order is preserved globally and therefore per flow.

Optional Feature:
- Macro: RPC_TX_STEER_STATS_EN.
- Defined: adds outputs drop_cnt_out (32 bits, saturating, counts pdrop pulses) and fwd_cnt_out (32 bits, wrapping, counts rpc_out_valid). Both are cleared by reset.
- Undefined: neither port nor counter exists; the remaining behaviour is identical.

Decomposition:
- Shared package nic_defs: RpcIf, RpcPckt and LMAX_CCIP_BATCH (existing). Add a new typedef ConnId and a FlowSteerEntry struct {valid, flow}.
- Sub-module: rpc_steer_fifo, a synchronous single-clock FIFO with count, full/empty and simultaneous push/pop. It is parameterised by DATA_WIDTH and LDEPTH.

Test Plan:
- Table conn 5 -> flow 1, number_of_flows=1; send RPC on conn 5 with ready high -> rpc_out_valid at N+3, rpc_flow_id_out=1, payload matches.
- Unprogrammed conn 3, number_of_flows=1 -> flow 1 (3 & 1). Conn 2 with number_of_flows=0 -> flow 0.
- ready low, then 10 back-to-back RPCs at depth 8 -> 8 buffered, 2 pdrop_out pulses (drop_cnt=2 with stats enabled). On raising ready, 8 outputs arrive in order on consecutive cycles.
- Full FIFO with simultaneous push and pop -> no drop, occupancy unchanged.
- Table write to conn 7 in the same cycle as an RPC on conn 7 -> old/fallback flow used; an RPC on the next cycle uses the new flow.
- Reset asserted with 4 entries queued -> no outputs after reset, fifo_empty=1, pdrop_out stays 0.
